// File: rtl/pc_defs.sv
// Shared parameter defaults and command encoding for the PC / return stack.
package pc_defs;

   localparam int          DEF_N        = 64;
   localparam int          DEF_DEPTH    = 8;
   localparam int          DEF_STEP     = 4;
   localparam logic [63:0] DEF_RESET_PC = 64'h0;

   typedef enum logic [2:0] {
      CMD_HOLD  = 3'd0,
      CMD_EN    = 3'd1,
      CMD_LOAD  = 3'd2,
      CMD_CALL  = 3'd3,
      CMD_RET   = 3'd4,
      CMD_STALL = 3'd5
   } cmd_e;

   // Fixed priority: stall > ret > call > l > en > hold.
   function automatic cmd_e decode_cmd(
      input logic stall,
      input logic ret,
      input logic call,
      input logic l,
      input logic en
   );
      cmd_e c;
      if (stall)     c = CMD_STALL;
      else if (ret)  c = CMD_RET;
      else if (call) c = CMD_CALL;
      else if (l)    c = CMD_LOAD;
      else if (en)   c = CMD_EN;
      else           c = CMD_HOLD;
      return c;
   endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack with count, pointer and sticky
// overflow/underflow flags.
module pc_ras
   import pc_defs::*;
#(
   parameter int N     = DEF_N,
   parameter int DEPTH = DEF_DEPTH,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic          pop,
   input  logic [N-1:0]  data,
   output logic [N-1:0]  top,
   output logic [CW-1:0] count,
   output logic          empty,
   output logic          full,
   output logic          ovf,
   output logic          unf
);

   logic [N-1:0]  mem [DEPTH];
   logic [AW-1:0] ptr;

   assign empty = (count == '0);
   assign full  = (count == CW'(DEPTH));
   assign top   = mem[ptr - AW'(1)];

   // ptr is the next free slot; when full it also marks the oldest entry,
   // so a push while full overwrites exactly that entry.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr   <= '0;
         count <= '0;
         ovf   <= 1'b0;
         unf   <= 1'b0;
      end else if (push) begin
         ptr <= ptr + AW'(1);
         if (full) ovf   <= 1'b1;
         else      count <= count + CW'(1);
      end else if (pop) begin
         if (empty) begin
            unf <= 1'b1;
         end else begin
            ptr   <= ptr - AW'(1);
            count <= count - CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[ptr] <= data;
   end

endmodule

// File: rtl/pc_stack_reg.sv
// Program counter with jump, call/return via a return-address stack,
// and stall; next-PC selection and the q register live here.
module pc_stack_reg
   import pc_defs::*;
#(
   parameter int          N        = DEF_N,
   parameter int          DEPTH    = DEF_DEPTH,
   parameter int          STEP     = DEF_STEP,
   parameter logic [N-1:0] RESET_PC = N'(DEF_RESET_PC)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic         stall,
   input  logic         l,
   input  logic         call,
   input  logic         ret,
   input  logic [N-1:0] r,
   output logic [N-1:0] q,
   output logic         ras_empty,
   output logic         ras_full,
   output logic         ras_ovf,
   output logic         ras_unf
);

   localparam int CW = $clog2(DEPTH) + 1;

   cmd_e          cmd;
   logic [N-1:0]  q_seq;
   logic [N-1:0]  q_next;
   logic [N-1:0]  ras_top;
   logic [CW-1:0] ras_count;
   logic          push;
   logic          pop;

   assign cmd   = decode_cmd(stall, ret, call, l, en);
   assign q_seq = q + N'(STEP);
   assign push  = (cmd == CMD_CALL);
   assign pop   = (cmd == CMD_RET);

   pc_ras #(
      .N     (N),
      .DEPTH (DEPTH)
   ) u_ras (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .data  (q_seq),
      .top   (ras_top),
      .count (ras_count),
      .empty (ras_empty),
      .full  (ras_full),
      .ovf   (ras_ovf),
      .unf   (ras_unf)
   );

   // A return on an empty stack falls through to the next sequential PC.
   always_comb begin
      q_next = q;
      unique case (cmd)
         CMD_RET:  q_next = ras_empty ? q_seq : ras_top;
         CMD_CALL: q_next = r;
         CMD_LOAD: q_next = r;
         CMD_EN:   q_next = q_seq;
         default:  q_next = q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) q <= RESET_PC;
      else       q <= q_next;
   end

endmodule

// File: tb/tb_pc_stack_reg.sv
// Scoreboard bench for pc_stack_reg (N=64, DEPTH=4, STEP=4, RESET_PC=0).
module tb_pc_stack_reg;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        en = 0, stall = 0, l = 0, call = 0, ret = 0;
   logic [63:0] r = '0;
   logic [63:0] q;
   logic        ras_empty, ras_full, ras_ovf, ras_unf;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [63:0] sb [$];
   logic [63:0] e;

   always #5 clk = ~clk;

   pc_stack_reg #(
      .N(64), .DEPTH(4), .STEP(4), .RESET_PC(64'h0)
   ) dut (
      .clk(clk), .reset(reset), .en(en), .stall(stall), .l(l),
      .call(call), .ret(ret), .r(r), .q(q),
      .ras_empty(ras_empty), .ras_full(ras_full),
      .ras_ovf(ras_ovf), .ras_unf(ras_unf)
   );

   task automatic apply(input logic s, input logic rt, input logic c,
                        input logic ld, input logic e_in,
                        input logic [63:0] tgt);
      @(negedge clk);
      stall = s; ret = rt; call = c; l = ld; en = e_in; r = tgt;
      @(posedge clk);
      #1;
      stall = 0; ret = 0; call = 0; l = 0; en = 0;
   endtask

   task automatic test_reset();
      #2;
      n_tests++;
      if (q !== 64'h0 || ras_empty !== 1'b1 || ras_full !== 1'b0 ||
          ras_ovf !== 1'b0 || ras_unf !== 1'b0) begin
         n_fail++;
         $display("FAIL reset q=%h e=%b f=%b o=%b u=%b exp q=0 e=1 f=0 o=0 u=0",
                  q, ras_empty, ras_full, ras_ovf, ras_unf);
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_seq();
      for (int i = 1; i <= 3; i++) begin
         sb.push_back(64'(4 * i));
         apply(0, 0, 0, 0, 1, '0);
         e = sb.pop_front();
         n_tests++;
         if (q !== e || ras_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL seq%0d q=%h empty=%b exp q=%h empty=1",
                     i, q, ras_empty, e);
         end
      end
   endtask

   task automatic test_call_ret();
      apply(0, 0, 0, 1, 0, 64'h100);
      sb.push_back(64'h2000);
      apply(0, 0, 1, 0, 0, 64'h2000);
      e = sb.pop_front();
      n_tests++;
      if (q !== e || ras_empty !== 1'b0) begin
         n_fail++;
         $display("FAIL call q=%h empty=%b exp q=%h empty=0", q, ras_empty, e);
      end
      sb.push_back(64'h104);
      apply(0, 1, 0, 0, 0, '0);
      e = sb.pop_front();
      n_tests++;
      if (q !== e || ras_empty !== 1'b1) begin
         n_fail++;
         $display("FAIL ret q=%h empty=%b exp q=%h empty=1", q, ras_empty, e);
      end
      // ret+call+l together: only the ret happens
      apply(0, 0, 1, 0, 0, 64'h300);
      sb.push_back(64'h108);
      apply(0, 1, 1, 1, 1, 64'h999);
      e = sb.pop_front();
      n_tests++;
      if (q !== e || ras_empty !== 1'b1 || ras_unf !== 1'b0) begin
         n_fail++;
         $display("FAIL prio q=%h empty=%b unf=%b exp q=%h empty=1 unf=0",
                  q, ras_empty, ras_unf, e);
      end
   endtask

   task automatic test_overflow();
      apply(0, 0, 0, 1, 0, 64'h0);
      for (int i = 1; i <= 5; i++) begin
         sb.push_back(64'(16 * i - 12));
         apply(0, 0, 1, 0, 0, 64'(16 * i));
      end
      n_tests++;
      if (q !== 64'h50 || ras_full !== 1'b1 || ras_ovf !== 1'b1) begin
         n_fail++;
         $display("FAIL ovf q=%h full=%b ovf=%b exp q=50 full=1 ovf=1",
                  q, ras_full, ras_ovf);
      end
      void'(sb.pop_front());
      for (int i = 0; i < 4; i++) begin
         apply(0, 1, 0, 0, 0, '0);
         e = sb.pop_back();
         n_tests++;
         if (q !== e) begin
            n_fail++;
            $display("FAIL ovf_ret%0d q=%h exp %h", i, q, e);
         end
      end
      n_tests++;
      if (ras_empty !== 1'b1 || ras_full !== 1'b0 || ras_ovf !== 1'b1) begin
         n_fail++;
         $display("FAIL ovf_drain e=%b f=%b o=%b exp e=1 f=0 o=1",
                  ras_empty, ras_full, ras_ovf);
      end
   endtask

   task automatic test_underflow();
      apply(0, 0, 0, 1, 0, 64'h50);
      sb.push_back(64'h54);
      apply(0, 1, 0, 0, 0, '0);
      e = sb.pop_front();
      n_tests++;
      if (q !== e || ras_unf !== 1'b1 || ras_empty !== 1'b1) begin
         n_fail++;
         $display("FAIL unf q=%h unf=%b empty=%b exp q=%h unf=1 empty=1",
                  q, ras_unf, ras_empty, e);
      end
      sb.push_back(64'h58);
      apply(0, 0, 0, 0, 1, '0);
      apply(0, 0, 0, 0, 0, '0);
      e = sb.pop_front();
      n_tests++;
      if (q !== e || ras_unf !== 1'b1) begin
         n_fail++;
         $display("FAIL unf_sticky q=%h unf=%b exp q=%h unf=1", q, ras_unf, e);
      end
   endtask

   task automatic test_wrap_stall();
      apply(0, 0, 0, 1, 0, 64'hFFFF_FFFF_FFFF_FFFC);
      sb.push_back(64'h0);
      apply(0, 0, 0, 0, 1, '0);
      e = sb.pop_front();
      n_tests++;
      if (q !== e) begin
         n_fail++;
         $display("FAIL wrap q=%h exp %h", q, e);
      end
      apply(0, 0, 1, 0, 0, 64'h1000);
      sb.push_back(64'h1000);
      apply(1, 0, 1, 1, 1, 64'h3000);
      e = sb.pop_front();
      n_tests++;
      if (q !== e || ras_empty !== 1'b0 || ras_full !== 1'b0) begin
         n_fail++;
         $display("FAIL stall q=%h empty=%b full=%b exp q=%h empty=0 full=0",
                  q, ras_empty, ras_full, e);
      end
      sb.push_back(64'h4);
      apply(0, 1, 0, 0, 0, '0);
      e = sb.pop_front();
      n_tests++;
      if (q !== e || ras_empty !== 1'b1) begin
         n_fail++;
         $display("FAIL stall_ret q=%h empty=%b exp q=%h empty=1",
                  q, ras_empty, e);
      end
   endtask

   task automatic test_async_reset();
      apply(0, 0, 1, 0, 0, 64'h700);
      apply(0, 0, 0, 0, 1, '0);
      @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      n_tests++;
      if (q !== 64'h0 || ras_ovf !== 1'b0 || ras_unf !== 1'b0 ||
          ras_empty !== 1'b1 || ras_full !== 1'b0) begin
         n_fail++;
         $display("FAIL areset q=%h o=%b u=%b e=%b f=%b exp q=0 o=0 u=0 e=1 f=0",
                  q, ras_ovf, ras_unf, ras_empty, ras_full);
      end
      @(negedge clk);
      reset = 1'b0;
      sb.push_back(64'h4);
      apply(0, 0, 0, 0, 1, '0);
      e = sb.pop_front();
      n_tests++;
      if (q !== e || ras_empty !== 1'b1) begin
         n_fail++;
         $display("FAIL post_reset q=%h empty=%b exp q=%h empty=1",
                  q, ras_empty, e);
      end
   endtask

   initial begin
      test_reset();
      test_seq();
      test_call_ret();
      test_overflow();
      test_underflow();
      test_wrap_stall();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
